// File: rtl/board_game_pkg.sv
// Shared encodings for the N x N K-in-a-row board game engine.
package board_game_pkg;

    // Two bits per cell
    localparam logic [1:0] EMPTY  = 2'b00;
    localparam logic [1:0] CELL_X = 2'b01;
    localparam logic [1:0] CELL_O = 2'b10;

    // Rejection reasons
    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_RANGE    = 3'd1,
        ERR_TURN     = 3'd2,
        ERR_OCCUPIED = 3'd3,
        ERR_BUSY     = 3'd4,
        ERR_GAMEOVER = 3'd5
    } err_code_e;

    // FSM states
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CHECK0 = 3'd1;
    localparam logic [2:0] S_CHECK1 = 3'd2;
    localparam logic [2:0] S_CHECK2 = 3'd3;
    localparam logic [2:0] S_CHECK3 = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    // Row step per direction: horizontal, vertical, diagonal, anti-diagonal
    function automatic int dir_dr(input logic [1:0] d);
        return (d == 2'd0) ? 0 : 1;
    endfunction

    // Column step per direction
    function automatic int dir_dc(input logic [1:0] d);
        case (d)
            2'd0:    return 1;
            2'd1:    return 0;
            2'd2:    return 1;
            default: return -1;
        endcase
    endfunction

    // Cell code written for a given mover
    function automatic logic [1:0] owner_code(input logic p);
        return p ? CELL_O : CELL_X;
    endfunction

endpackage

// File: rtl/board_game_nxn_line_counter.sv
// Combinational run-length counter along one direction through an origin cell.
module line_counter
    import board_game_pkg::*;
#(
    parameter int unsigned N = 3,
    parameter int unsigned K = 3,
    localparam int unsigned CW = (N <= 4) ? 2 : $clog2(N),
    localparam int unsigned BW = 2 * N * N,
    localparam int unsigned IW = $clog2(BW),
    localparam int unsigned RW = $clog2(2 * K)
) (
    input  logic [BW-1:0] board,
    input  logic [CW-1:0] org_row,
    input  logic [CW-1:0] org_col,
    input  logic [1:0]    dir,
    input  logic [1:0]    owner,
    output logic [RW-1:0] run_len_c
);

    int   dr, dc, fwd, bwd;
    logic run_f, run_b;

    // True when (r,c) is on the board and held by own
    function automatic logic cell_hit(input logic [BW-1:0] b, input logic [1:0] own,
                                      input int r, input int c);
        logic          inb;
        logic [IW-1:0] idx;
        inb = (r >= 0) && (r < int'(N)) && (c >= 0) && (c < int'(N));
        idx = inb ? IW'(2 * (r * int'(N) + c)) : '0;
        return inb && (b[idx +: 2] == own);
    endfunction

    // Walk both ways from the origin; each side stops at K-1, a gap or the edge
    always_comb begin
        dr    = dir_dr(dir);
        dc    = dir_dc(dir);
        fwd   = 0;
        bwd   = 0;
        run_f = 1'b1;
        run_b = 1'b1;
        for (int i = 1; i < int'(K); i++) begin
            run_f = run_f && cell_hit(board, owner, int'(org_row) + i * dr, int'(org_col) + i * dc);
            run_b = run_b && cell_hit(board, owner, int'(org_row) - i * dr, int'(org_col) - i * dc);
            if (run_f) fwd = fwd + 1;
            if (run_b) bwd = bwd + 1;
        end
        run_len_c = RW'(1 + fwd + bwd);
    end

endmodule

// File: rtl/board_game_nxn.sv
// N x N K-in-a-row game engine: board storage, turn checks, 4-direction win scan.
module board_game_nxn
    import board_game_pkg::*;
#(
    parameter int unsigned N = 3,
    parameter int unsigned K = 3,
    localparam int unsigned CW  = (N <= 4) ? 2 : $clog2(N),
    localparam int unsigned MCW = $clog2(N * N + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clear,
    input  logic           update,
    input  logic           player,
    input  logic [CW-1:0]  row,
    input  logic [CW-1:0]  col,
    output logic           ready,
    output logic           gameOver,
    output logic           winner,
    output logic           draw,
    output logic           ERR,
    output logic [2:0]     err_code,
    output logic [MCW-1:0] move_count
);

    localparam int unsigned BW = 2 * N * N;
    localparam int unsigned IW = $clog2(BW);
    localparam int unsigned RW = $clog2(2 * K);

    logic [2:0]     state_q, state_d;
    logic [BW-1:0]  board_q, board_d;
    logic           exp_q, exp_d;
    logic [CW-1:0]  lrow_q, lrow_d, lcol_q, lcol_d;
    logic           lply_q, lply_d;
    logic           game_over_q, game_over_d;
    logic           winner_q, winner_d;
    logic           draw_q, draw_d;
    logic           err_q, err_d;
    err_code_e      err_code_q, err_code_d;
    logic [MCW-1:0] mc_q, mc_d;
    logic           ready_q, ready_d;

    logic           in_rng;
    logic [IW-1:0]  cell_idx;
    logic [1:0]     cur_cell;
    logic [1:0]     dir;
    logic [RW-1:0]  run_len_c;

    // Shared counter; the direction follows the current CHECK state
    assign dir = 2'(state_q - S_CHECK0);

    line_counter #(.N(N), .K(K)) u_line_counter (
        .board     (board_q),
        .org_row   (lrow_q),
        .org_col   (lcol_q),
        .dir       (dir),
        .owner     (owner_code(lply_q)),
        .run_len_c (run_len_c)
    );

    // Decode of the requested cell
    always_comb begin
        in_rng   = (int'(row) < int'(N)) && (int'(col) < int'(N));
        cell_idx = in_rng ? IW'(2 * (int'(row) * int'(N) + int'(col))) : '0;
        cur_cell = board_q[cell_idx +: 2];
    end

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        board_d     = board_q;
        exp_d       = exp_q;
        lrow_d      = lrow_q;
        lcol_d      = lcol_q;
        lply_d      = lply_q;
        game_over_d = game_over_q;
        winner_d    = winner_q;
        draw_d      = draw_q;
        err_d       = 1'b0;
        err_code_d  = err_code_q;
        mc_d        = mc_q;

        if (clear) begin
            state_d     = S_IDLE;
            board_d     = '0;
            exp_d       = 1'b0;
            lrow_d      = '0;
            lcol_d      = '0;
            lply_d      = 1'b0;
            game_over_d = 1'b0;
            winner_d    = 1'b0;
            draw_d      = 1'b0;
            err_code_d  = ERR_NONE;
            mc_d        = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (update) begin
                        if (!in_rng) begin
                            err_d      = 1'b1;
                            err_code_d = ERR_RANGE;
                        end else if (player != exp_q) begin
                            err_d      = 1'b1;
                            err_code_d = ERR_TURN;
                        end else if (cur_cell != EMPTY) begin
                            err_d      = 1'b1;
                            err_code_d = ERR_OCCUPIED;
                        end else begin
                            board_d[cell_idx +: 2] = owner_code(player);
                            mc_d       = mc_q + MCW'(1);
                            lrow_d     = row;
                            lcol_d     = col;
                            lply_d     = player;
                            err_code_d = ERR_NONE;
                            state_d    = S_CHECK0;
                        end
                    end
                end
                S_CHECK0, S_CHECK1, S_CHECK2, S_CHECK3: begin
                    if (update) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_BUSY;
                    end
                    if (int'(run_len_c) >= int'(K)) begin
                        winner_d    = lply_q;
                        game_over_d = 1'b1;
                        state_d     = S_DONE;
                    end else if (state_q == S_CHECK3) begin
                        if (mc_q == MCW'(N * N)) begin
                            draw_d      = 1'b1;
                            game_over_d = 1'b1;
                            state_d     = S_DONE;
                        end else begin
                            exp_d   = ~exp_q;
                            state_d = S_IDLE;
                        end
                    end else begin
                        state_d = state_q + 3'd1;
                    end
                end
                S_DONE: begin
                    if (update) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_GAMEOVER;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        ready_d = (state_d == S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            board_q     <= '0;
            exp_q       <= 1'b0;
            lrow_q      <= '0;
            lcol_q      <= '0;
            lply_q      <= 1'b0;
            game_over_q <= 1'b0;
            winner_q    <= 1'b0;
            draw_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
            mc_q        <= '0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            board_q     <= board_d;
            exp_q       <= exp_d;
            lrow_q      <= lrow_d;
            lcol_q      <= lcol_d;
            lply_q      <= lply_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
            draw_q      <= draw_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            mc_q        <= mc_d;
            ready_q     <= ready_d;
        end
    end

    assign ready      = ready_q;
    assign gameOver   = game_over_q;
    assign winner     = winner_q;
    assign draw       = draw_q;
    assign ERR        = err_q;
    assign err_code   = err_code_q;
    assign move_count = mc_q;

endmodule

// File: doc/board_game_nxn.md
Name: board_game_nxn

Overview:
- Parametrised N x N, K-in-a-row successor of the 3x3 tic-tac-toe engine.
- Stores the board and enforces alternating turns. Rejects illegal moves with an error code.
- After each accepted move, runs a 4-cycle directional win check centred on the placed cell.
- Reports win, draw and game-over status to the surrounding display/input logic.

Parameters:
- N, 3, board side length; legal range 3..15.
- K, 3, contiguous marks needed to win; legal range 3..N.
- CW, $clog2(N) (minimum 2), coordinate width; derived, not overridden.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous new-game request; wins over update in the same cycle.
- update  input  1  move request, sampled when ready=1.
- player  input  1  mover identity: 0=X, 1=O.
- row  input  CW  move row.
- col  input  CW  move column.
- ready  output  1  high in IDLE only.
- gameOver  output  1  high once a win or draw is decided.
- winner  output  1  player that completed the line; valid while gameOver=1 and draw=0.
- draw  output  1  board full with no line.
- ERR  output  1  one-cycle pulse on a rejected request.
- err_code  output  3  reason for the last rejection; held until the next update.
- move_count  output  $clog2(N*N+1)  number of accepted moves.

Behaviour:
- Reset (async) and clear (sync) have the same effect:
  - all cells empty, state=IDLE, next player=X;
  - gameOver=0, winner=0, draw=0, ERR=0, err_code=NONE, move_count=0, ready=1.
- Cell storage: 2 bits per cell: 00 empty, 01 X, 10 O.
- FSM states: IDLE, CHECK0..CHECK3, DONE.
- IDLE + update: checks are applied in priority order. First failure sets ERR=1 for one cycle, loads err_code, leaves the board unchanged and stays in IDLE.
  1. row>=N or col>=N -> RANGE.
  2. player != expected -> TURN.
  3. cell occupied -> OCCUPIED.
- IDLE + update with no failure:
  - write the cell;
  - increment move_count;
  - latch row/col/player;
  - err_code=NONE;
  - go to CHECK0.
- CHECKd (d = 0 horizontal, 1 vertical, 2 diagonal, 3 anti-diagonal):
  - count contiguous same-owner cells from the latched cell, both ways along direction d;
  - each side saturates at K-1 and stops at the board edge;
  - total = 1 + left + right.
  - If total >= K: winner=latched player, gameOver=1, go to DONE.
  - Otherwise advance to the next direction.
- After CHECK3 with no win:
  - if move_count==N*N: draw=1, gameOver=1, go to DONE;
  - else toggle the expected player and return to IDLE.
- Latency: ready is low for 4 cycles after an accepted move, fewer if an earlier direction wins. A win is always decided no later than cycle 4. Verification checks outcomes, not the exact exit cycle.
- update while ready=0 (CHECK or DONE):
  - ERR pulse, err_code=BUSY in CHECK, GAMEOVER in DONE;
  - no state change.
- DONE: holds all outputs until clear or rst.
- A move that completes a line as the final cell reports a win, not a draw.
- Reset mid-CHECK aborts the check immediately; nothing is retained.

Decomposition:
- Shared package board_game_pkg:
  - cell encoding constants (EMPTY, CELL_X, CELL_O);
  - err_code enum (NONE=0, RANGE=1, TURN=2, OCCUPIED=3, BUSY=4, GAMEOVER=5);
  - FSM state enum;
  - direction offset constants (dr, dc per direction).
- Sub-module line_counter (parameters N, K):
  - inputs: flattened board, origin row/col, direction, owner;
  - output: saturated run length.
  - Purely combinational; instanced once and shared across CHECK states via the direction select.

Test Plan:
- N=3,K=3: X(0,0), O(1,0), X(0,1), O(1,1), X(0,2) -> gameOver=1 and winner=0 after the last move's check; draw=0; move_count=5.
- N=3,K=3: nine legal alternating moves with no line (X:00,02,11,12? no — use X:00,01,12,20,22 / O:02,10,11,21) -> draw=1, gameOver=1, move_count=9.
- N=3: O moves first -> ERR pulse, err_code=2, board empty. Then X at (1,1), then O at (1,1) -> err_code=3, move_count=1.
- N=5,K=4: anti-diagonal X at (0,4),(1,3),(3,1),(2,2), with O moves interleaved off-line -> win detected through a two-sided count (1+1+2); winner=0.
- update during CHECK -> err_code=4. update in DONE -> err_code=5. clear -> all outputs return to reset values the next cycle.
- rst asserted asynchronously mid-CHECK1 -> outputs at reset values before the next clk edge; the next legal X move is accepted.
